// File: rtl/cdb_arbiter.sv
// Buffered round-robin common data bus: per-source FIFOs feeding NUM_LANES registered lanes.
// Optional feature macro: CDB_PERF_EN adds saturating broadcast/stall performance counters.
module cdb_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int NUM_LANES = 2,
  parameter int DATA_W    = 32,
  parameter int ROB_DEPTH = 4,
  parameter int BUF_DEPTH = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush,
  input  logic [NUM_SRC-1:0]                   exe_valid,
  output logic [NUM_SRC-1:0]                   exe_ready,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]       exe_alu_f,
  input  logic [NUM_SRC-1:0][ROB_DEPTH-1:0]    exe_rob,
  output logic [NUM_LANES-1:0]                 cdb_valid,
  output logic [NUM_LANES-1:0][DATA_W-1:0]     cdb_rd_v,
  output logic [NUM_LANES-1:0][ROB_DEPTH-1:0]  cdb_rob
`ifdef CDB_PERF_EN
  ,
  output logic [31:0]                          perf_bcast_cnt,
  output logic [31:0]                          perf_stall_cnt
`endif
);

  localparam int AW    = $clog2(BUF_DEPTH);
  localparam int PW    = AW + 1;
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int ENT_W = DATA_W + ROB_DEPTH;

  typedef logic [ENT_W-1:0] entry_t;

  entry_t                              mem_q    [NUM_SRC][BUF_DEPTH];
  logic [PW-1:0]                       wr_ptr_q [NUM_SRC];
  logic [PW-1:0]                       rd_ptr_q [NUM_SRC];
  logic [SRC_W-1:0]                    rr_ptr_q;
  logic [SRC_W-1:0]                    rr_ptr_d;
  logic [NUM_LANES-1:0]                cdb_valid_q;
  logic [NUM_LANES-1:0][DATA_W-1:0]    cdb_rd_v_q;
  logic [NUM_LANES-1:0][ROB_DEPTH-1:0] cdb_rob_q;

  logic [NUM_SRC-1:0]                  empty_s;
  logic [NUM_SRC-1:0]                  full_s;
  logic [NUM_SRC-1:0]                  push_s;
  logic [NUM_SRC-1:0]                  pop_s;
  logic [NUM_LANES-1:0]                lane_vld_s;
  logic [SRC_W-1:0]                    lane_src_s [NUM_LANES];
  entry_t                              lane_ent_s [NUM_LANES];
  logic [SRC_W-1:0]                    sel_src_s;
  int                                  sel_cnt_s;
  logic                                taken_s;

  // FIFO occupancy: extra pointer MSB distinguishes full from empty
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      empty_s[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      full_s[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                   (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
    end
  end

  assign exe_ready = ~full_s;
  assign push_s    = exe_valid & ~full_s;

  // Round-robin scan from rr_ptr; the k-th non-empty head found drives lane k
  always_comb begin
    pop_s      = '0;
    lane_vld_s = '0;
    rr_ptr_d   = rr_ptr_q;
    sel_cnt_s  = 0;
    sel_src_s  = '0;
    taken_s    = 1'b0;
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_src_s[l] = '0;
    end
    for (int k = 0; k < NUM_SRC; k++) begin
      sel_src_s = SRC_W'((int'(rr_ptr_q) + k) % NUM_SRC);
      taken_s   = 1'b0;
      if (!empty_s[sel_src_s] && (sel_cnt_s < NUM_LANES)) begin
        for (int l = 0; l < NUM_LANES; l++) begin
          if (!taken_s && (sel_cnt_s == l)) begin
            lane_vld_s[l] = 1'b1;
            lane_src_s[l] = sel_src_s;
            taken_s       = 1'b1;
          end else begin
            taken_s       = taken_s;
          end
        end
        pop_s[sel_src_s] = 1'b1;
        sel_cnt_s        = sel_cnt_s + 1;
        rr_ptr_d         = SRC_W'((int'(sel_src_s) + 1) % NUM_SRC);
      end else begin
        sel_cnt_s        = sel_cnt_s;
      end
    end
  end

  // Head entry of the source granted to each lane
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_ent_s[l] = mem_q[lane_src_s[l]][rd_ptr_q[lane_src_s[l]][AW-1:0]];
    end
  end

  // FIFO storage, pointers, round-robin pointer and registered broadcast lanes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        for (int j = 0; j < BUF_DEPTH; j++) begin
          mem_q[i][j] <= '0;
        end
      end
      rr_ptr_q    <= '0;
      cdb_valid_q <= '0;
      cdb_rd_v_q  <= '0;
      cdb_rob_q   <= '0;
    end else if (flush) begin
      // Lane data is held; only the valids drop. rr_ptr keeps its position.
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
      cdb_valid_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push_s[i]) begin
          mem_q[i][wr_ptr_q[i][AW-1:0]] <= {exe_alu_f[i], exe_rob[i]};
          wr_ptr_q[i]                   <= wr_ptr_q[i] + PW'(1);
        end
        if (pop_s[i]) begin
          rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
        end
      end
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= lane_vld_s;
      for (int l = 0; l < NUM_LANES; l++) begin
        if (lane_vld_s[l]) begin
          cdb_rd_v_q[l] <= lane_ent_s[l][ENT_W-1:ROB_DEPTH];
          cdb_rob_q[l]  <= lane_ent_s[l][ROB_DEPTH-1:0];
        end
      end
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_rd_v  = cdb_rd_v_q;
  assign cdb_rob   = cdb_rob_q;

`ifdef CDB_PERF_EN
  logic [31:0] perf_bcast_q;
  logic [31:0] perf_stall_q;
  logic [32:0] bcast_sum_s;
  logic [32:0] stall_sum_s;

  // One extra bit on the sums exposes overflow for saturation
  always_comb begin
    bcast_sum_s = {1'b0, perf_bcast_q} + (flush ? 33'd0 : 33'($countones(lane_vld_s)));
    stall_sum_s = {1'b0, perf_stall_q} + {32'd0, |(exe_valid & ~exe_ready)};
  end

  // Saturating counters, cleared by reset only
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_bcast_q <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      perf_bcast_q <= bcast_sum_s[32] ? 32'hFFFF_FFFF : bcast_sum_s[31:0];
      perf_stall_q <= stall_sum_s[32] ? 32'hFFFF_FFFF : stall_sum_s[31:0];
    end
  end

  assign perf_bcast_cnt = perf_bcast_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

  cdb_arbiter_chk #(.NUM_LANES(NUM_LANES)) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .cdb_valid (cdb_valid_q)
  );

endmodule

// Protocol properties of the broadcast lanes.
module cdb_arbiter_chk #(
  parameter int NUM_LANES = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic                 flush,
  input logic [NUM_LANES-1:0] cdb_valid
);

  // Lanes fill from lane 0 upward, so valid is always a contiguous low mask
  a_lanes_packed: assert property (@(posedge clk) disable iff (!rst_n)
    ((cdb_valid & (cdb_valid + NUM_LANES'(1))) == '0));

  a_flush_clears: assert property (@(posedge clk) disable iff (!rst_n)
    flush |=> (cdb_valid == '0));

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: queue-level reference model plus directed literal checks.
module tb_cdb_arbiter;

  localparam int NS = 4;
  localparam int NL = 2;
  localparam int DW = 32;
  localparam int RW = 4;
  localparam int BD = 2;

  typedef logic [DW+RW-1:0] ent_t;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   flush;
  logic [NS-1:0]          exe_valid;
  logic [NS-1:0]          exe_ready;
  logic [NS-1:0][DW-1:0]  exe_alu_f;
  logic [NS-1:0][RW-1:0]  exe_rob;
  logic [NL-1:0]          cdb_valid;
  logic [NL-1:0][DW-1:0]  cdb_rd_v;
  logic [NL-1:0][RW-1:0]  cdb_rob;
`ifdef CDB_PERF_EN
  logic [31:0]            perf_bcast_cnt;
  logic [31:0]            perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_SRC(NS), .NUM_LANES(NL), .DATA_W(DW), .ROB_DEPTH(RW), .BUF_DEPTH(BD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .exe_valid (exe_valid),
    .exe_ready (exe_ready),
    .exe_alu_f (exe_alu_f),
    .exe_rob   (exe_rob),
    .cdb_valid (cdb_valid),
    .cdb_rd_v  (cdb_rd_v),
    .cdb_rob   (cdb_rob)
`ifdef CDB_PERF_EN
    ,
    .perf_bcast_cnt (perf_bcast_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one queue per source, a round-robin start index and the lane image
  ent_t          mq [NS][$];
  int            mrr;
  logic [NL-1:0] m_valid;
  logic [DW-1:0] m_data [NL];
  logic [RW-1:0] m_rob  [NL];
  bit            model_live = 1'b0;

  task automatic model_step();
    int   pre [NS];
    int   lane;
    int   last;
    int   s;
    ent_t e;
    if (!rst_n) begin
      for (int i = 0; i < NS; i++) mq[i].delete();
      mrr = 0;
      m_valid = '0;
      for (int l = 0; l < NL; l++) begin
        m_data[l] = '0;
        m_rob[l]  = '0;
      end
      model_live = 1'b1;
    end else if (flush) begin
      for (int i = 0; i < NS; i++) mq[i].delete();
      m_valid = '0;
    end else begin
      for (int i = 0; i < NS; i++) pre[i] = mq[i].size();
      m_valid = '0;
      lane = 0;
      last = -1;
      for (int k = 0; k < NS; k++) begin
        s = (mrr + k) % NS;
        if (pre[s] > 0 && lane < NL) begin
          e = mq[s].pop_front();
          m_valid[lane] = 1'b1;
          m_data[lane]  = e[DW+RW-1:RW];
          m_rob[lane]   = e[RW-1:0];
          lane++;
          last = s;
        end
      end
      if (last >= 0) mrr = (last + 1) % NS;
      for (int i = 0; i < NS; i++)
        if (exe_valid[i] && pre[i] < BD) mq[i].push_back({exe_alu_f[i], exe_rob[i]});
    end
  endtask

  always @(posedge clk) model_step();

  // Backpressure-phase bookkeeping shared with the compare process
  bit cnt_en  = 1'b0;
  bit fair_en = 1'b0;
  int ncyc = 0;
  int bc [NS];
  int last_seen [NS];
  int exp_seq0;

  // Compare process: DUT against the model every cycle once reset has been seen
  always @(negedge clk) begin
    int s;
    if (model_live) begin
      ncyc++;
      for (int l = 0; l < NL; l++) begin
        chk("lane_valid", cdb_valid[l], m_valid[l]);
        chk("lane_data",  cdb_rd_v[l],  m_data[l]);
        chk("lane_rob",   cdb_rob[l],   m_rob[l]);
      end
      for (int i = 0; i < NS; i++)
        chk("exe_ready", exe_ready[i], mq[i].size() < BD);
      if (cnt_en) begin
        for (int l = 0; l < NL; l++) begin
          if (cdb_valid[l]) begin
            s = int'(cdb_rd_v[l][31:24]);
            if (s < NS) begin
              bc[s]++;
              last_seen[s] = ncyc;
              if (s == 0) begin
                chk("src0_order", cdb_rd_v[l][23:0], 24'(exp_seq0));
                exp_seq0++;
              end
            end
          end
        end
      end
      if (fair_en)
        for (int i = 0; i < NS; i++) chk("fairness_gap", (ncyc - last_seen[i]) <= 2, 1'b1);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic [DW-1:0] d, input logic [RW-1:0] r);
    exe_valid[i] = 1'b1;
    exe_alu_f[i] = d;
    exe_rob[i]   = r;
  endtask

  int  seq [NS];
  bit  acc_rdy [NS];
  int  stall0;
  int  nvld;

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    exe_valid = '0;
    exe_alu_f = '0;
    exe_rob   = '0;

    // Reset held three edges
    repeat (3) cyc();
    rst_n = 1'b1;
    chk("reset_valid", cdb_valid, 2'b00);
    chk("reset_data", cdb_rd_v, 64'd0);
    cyc();
    chk("reset_ready", exe_ready, 4'hF);

    // Single source, two-edge latency, one-cycle pulse
    drive(2, 32'hDEAD_BEEF, 4'd5);
    cyc();
    exe_valid = '0;
    chk("single_not_yet", cdb_valid, 2'b00);
    cyc();
    chk("single_valid", cdb_valid, 2'b01);
    chk("single_data", cdb_rd_v[0], 32'hDEAD_BEEF);
    chk("single_rob", cdb_rob[0], 4'd5);
    cyc();
    chk("single_pulse", cdb_valid, 2'b00);

    // Contention from rr_ptr=0
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < NS; i++) drive(i, 32'h100 + 32'(i), 4'(i));
    cyc();
    exe_valid = '0;
    chk("cont_not_yet", cdb_valid, 2'b00);
    cyc();
    chk("cont_a_valid", cdb_valid, 2'b11);
    chk("cont_a_rob0", cdb_rob[0], 4'd0);
    chk("cont_a_rob1", cdb_rob[1], 4'd1);
    cyc();
    chk("cont_b_valid", cdb_valid, 2'b11);
    chk("cont_b_rob0", cdb_rob[0], 4'd2);
    chk("cont_b_rob1", cdb_rob[1], 4'd3);
    drive(3, 32'h0000_00A3, 4'hA);
    drive(0, 32'h0000_00B0, 4'hB);
    cyc();
    exe_valid = '0;
    cyc();
    chk("rr_wrap_rob0", cdb_rob[0], 4'hB);
    chk("rr_wrap_rob1", cdb_rob[1], 4'hA);

    // Reset mid-operation drops buffered results
    for (int i = 0; i < NS; i++) drive(i, 32'h200 + 32'(i), 4'(i));
    cyc();
    exe_valid = '0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    nvld = 0;
    repeat (3) begin
      cyc();
      nvld += $countones(cdb_valid);
    end
    chk("reset_drop", nvld, 0);

    // Backpressure: all sources push whenever they can
    for (int i = 0; i < NS; i++) begin
      seq[i] = 0;
      acc_rdy[i] = 1'b0;
      bc[i] = 0;
      last_seen[i] = ncyc;
    end
    exp_seq0 = 0;
    stall0 = 0;
    cnt_en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < NS; i++) if (exe_valid[i] && acc_rdy[i]) seq[i]++;
      for (int i = 0; i < NS; i++) begin
        drive(i, {8'(i), 24'(seq[i])}, 4'(seq[i]));
        acc_rdy[i] = mq[i].size() < BD;
      end
      if (!exe_ready[0]) stall0++;
      if (c == 6) fair_en = 1'b1;
      cyc();
    end
    for (int i = 0; i < NS; i++) if (exe_valid[i] && acc_rdy[i]) seq[i]++;
    exe_valid = '0;
    fair_en = 1'b0;
    repeat (8) cyc();
    cnt_en = 1'b0;
    chk("bp_ready_dropped", stall0 > 0, 1'b1);
    for (int i = 0; i < NS; i++) chk("bp_count", bc[i], seq[i]);

    // Flush with six results buffered and a src1 push in the same cycle
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < NS; i++) drive(i, 32'h5000 + 32'(i), 4'(8 + i));
    cyc();
    for (int i = 0; i < NS; i++) drive(i, 32'h6000 + 32'(i), 4'(12 + i));
    cyc();
    exe_valid = '0;
    flush = 1'b1;
    drive(1, 32'hBAD0_BAD0, 4'hF);
    cyc();
    flush = 1'b0;
    exe_valid = '0;
    chk("flush_valid", cdb_valid, 2'b00);
    chk("flush_ready", exe_ready, 4'hF);
    nvld = 0;
    repeat (5) begin
      cyc();
      nvld += $countones(cdb_valid);
    end
    chk("flush_quiet", nvld, 0);

`ifdef CDB_PERF_EN
    // Broadcast counter saturation
    force dut.perf_bcast_q = 32'hFFFF_FFFE;
    release dut.perf_bcast_q;
    drive(0, 32'h7000, 4'd1);
    drive(1, 32'h7001, 4'd2);
    cyc();
    exe_valid = '0;
    cyc();
    chk("perf_sat", perf_bcast_cnt, 32'hFFFF_FFFF);
    cyc();
    chk("perf_hold", perf_bcast_cnt, 32'hFFFF_FFFF);
`endif

    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
